// File: rtl/calc_display_driver.sv
// calc_display_driver: shows a signed 9-bit result on a 4-digit multiplexed 7-segment display.
// Latency: a load accepted in cycle 0 reaches the display register at the end of cycle 10; ready returns in cycle 11.
// Backpressure: ready is low for 10 cycles after each accept; a load while ready=0 is dropped, not queued.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   value_in[8:0]  signed two's-complement result (-256..255), qualified by load
//   load / ready   valid/ready handshake; the value is taken when both are high
//   anode_n[3:0]   one-hot active-low digit enables, bit 0 = rightmost digit
//   seg_n[6:0]     active-low segments gfedcba
//   dp_n           decimal point, always off (high)
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros in the
// hundreds and tens digits. The ones digit is always lit and the sign stays
// on digit 3. FSM, latency and scan timing are the same in both builds.

module calc_display_driver #(
  parameter int REFRESH_DIV = 50000,  // cycles each digit stays lit, >= 2
  parameter int CNT_W       = 16      // refresh counter width, 2**CNT_W >= REFRESH_DIV
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] value_in,
  input  logic       load,
  output logic       ready,
  output logic [3:0] anode_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_WRAP = CNT_W'(REFRESH_DIV - 1);

  state_t r_state;
  state_t w_state_nxt;

  // Conversion working set
  logic        r_sign;
  logic [8:0]  r_mag;
  logic [11:0] r_bcd;
  logic [3:0]  r_shift_cnt;

  // Display register: written only in LATCH, so the scanner never sees a
  // partially converted value.
  logic        r_disp_sign;
  logic [11:0] r_disp_bcd;

  // Scanner
  logic [CNT_W-1:0] r_ref_cnt;
  logic [1:0]       r_dig_idx;
  logic [3:0]       r_anode_n;
  logic [6:0]       r_seg_n;

  logic [8:0]  w_abs;
  logic [11:0] w_bcd_adj;
  logic [20:0] w_shift;
  logic        w_conv_done;
  logic        w_wrap;
  logic [3:0]  w_anode_dec;
  logic [6:0]  w_dig_seg;

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'h7F;  // 10..15 never produced by the converter
    endcase
    return s;
  endfunction

  // 9-bit magnitude: -256 (9'h100) negates to itself, which reads as 256 unsigned.
  assign w_abs = value_in[8] ? (~value_in + 9'd1) : value_in;

  // Double-dabble step: correct each nibble >= 5, then shift {bcd,mag} left.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) begin
        w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
      end
    end
  end

  assign w_shift     = {w_bcd_adj, r_mag} << 1;
  assign w_conv_done = (r_shift_cnt == 4'd8);  // this cycle performs the 9th shift

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (load) begin
          w_state_nxt = S_CONV;
        end
      end
      S_CONV: begin
        if (w_conv_done) begin
          w_state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign      <= 1'b0;
      r_mag       <= 9'd0;
      r_bcd       <= 12'd0;
      r_shift_cnt <= 4'd0;
      r_disp_sign <= 1'b0;
      r_disp_bcd  <= 12'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (load) begin
            r_sign      <= value_in[8];
            r_mag       <= w_abs;
            r_bcd       <= 12'd0;
            r_shift_cnt <= 4'd0;
          end
        end
        S_CONV: begin
          r_bcd       <= w_shift[20:9];
          r_mag       <= w_shift[8:0];
          r_shift_cnt <= r_shift_cnt + 4'd1;
        end
        S_LATCH: begin
          r_disp_sign <= r_sign;
          r_disp_bcd  <= r_bcd;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- scanner
  assign w_wrap      = (r_ref_cnt == LP_WRAP);
  assign w_anode_dec = ~(4'b0001 << r_dig_idx);

  always_comb begin
    w_dig_seg = 7'h7F;
    case (r_dig_idx)
      2'd0: w_dig_seg = f_seg(r_disp_bcd[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
      2'd1: w_dig_seg = (r_disp_bcd[11:4] == 8'd0) ? 7'h7F : f_seg(r_disp_bcd[7:4]);
      2'd2: w_dig_seg = (r_disp_bcd[11:8] == 4'd0) ? 7'h7F : f_seg(r_disp_bcd[11:8]);
`else
      2'd1: w_dig_seg = f_seg(r_disp_bcd[7:4]);
      2'd2: w_dig_seg = f_seg(r_disp_bcd[11:8]);
`endif
      2'd3: w_dig_seg = r_disp_sign ? 7'b0111111 : 7'h7F;
      default: w_dig_seg = 7'h7F;
    endcase
  end

  // Anode and segments are loaded on the same edge so a digit never shows
  // its neighbour's pattern. The first enable appears on the first wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ref_cnt <= '0;
      r_dig_idx <= 2'd0;
      r_anode_n <= 4'b1111;
      r_seg_n   <= 7'h7F;
    end else begin
      if (w_wrap) begin
        r_ref_cnt <= '0;
        r_dig_idx <= r_dig_idx + 2'd1;
        r_anode_n <= w_anode_dec;
        r_seg_n   <= w_dig_seg;
      end else begin
        r_ref_cnt <= r_ref_cnt + 1'b1;
      end
    end
  end

  assign anode_n = r_anode_n;
  assign seg_n   = r_seg_n;
  assign dp_n    = 1'b1;

endmodule

// File: tb/tb_calc_display_driver.sv
// tb_calc_display_driver: randomized and directed stimulus against a cycle-level reference model.
// The model tracks busy time, the displayed value and the scan position with plain arithmetic.
// Outputs are compared on every falling edge; inputs change right after the comparison.

module tb_calc_display_driver;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] value_in = 9'd0;
  logic       load = 1'b0;
  logic       ready;
  logic [3:0] anode_n;
  logic [6:0] seg_n;
  logic       dp_n;

  int n_cmp = 0;
  int n_mis = 0;

  calc_display_driver #(.REFRESH_DIV(DIV), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .value_in (value_in),
    .load     (load),
    .ready    (ready),
    .anode_n  (anode_n),
    .seg_n    (seg_n),
    .dp_n     (dp_n)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  // Expected segment pattern of digit k for a displayed signed value v.
  function automatic logic [6:0] exp_seg(input logic [8:0] v, input int k);
    int mag;
    int d [0:2];
    logic neg;
    neg = v[8];
    mag = neg ? 512 - int'(v) : int'(v);
    d[0] = mag % 10;
    d[1] = (mag / 10) % 10;
    d[2] = mag / 100;
    if (k == 3) return neg ? 7'b0111111 : 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
    if (k == 2 && d[2] == 0) return 7'h7F;
    if (k == 1 && d[2] == 0 && d[1] == 0) return 7'h7F;
`endif
    return seg_tab[d[k]];
  endfunction

  // Reference model
  int         m_e = 0;      // rising edges since reset
  int         m_busy = 0;   // cycles until the accepted value reaches the display
  int         m_k;
  logic [8:0] m_pend = 9'd0;
  logic [8:0] m_disp = 9'd0;
  logic [3:0] m_anode = 4'hF;
  logic [6:0] m_seg = 7'h7F;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e = 0; m_busy = 0; m_disp = 9'd0; m_anode = 4'hF; m_seg = 7'h7F;
    end else begin
      m_e = m_e + 1;
      if (m_e % DIV == 0) begin
        m_k = (m_e / DIV - 1) % 4;
        m_anode = ~(4'b0001 << m_k);
        m_seg = exp_seg(m_disp, m_k);   // value shown before any same-edge update
      end
      if (m_busy == 0) begin
        if (load) begin
          m_pend = value_in;
          m_busy = 10;
        end
      end else begin
        m_busy = m_busy - 1;
        if (m_busy == 0) m_disp = m_pend;
      end
    end
  end

  task automatic cyc(input logic ld, input logic [8:0] v);
    @(negedge clk);
    chk("ready", 32'(ready), 32'(m_busy == 0));
    chk("anode_n", 32'(anode_n), 32'(m_anode));
    chk("seg_n", 32'(seg_n), 32'(m_seg));
    chk("dp_n", 32'(dp_n), 32'd1);
    load = ld;
    value_in = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 9'd0);
  endtask

  initial begin
    // Reset and idle scan: blank until first wrap, then digits 0..3.
    idle(3);
    rst_n = 1'b1;
    idle(24);

    // 123 -> 3,2,1,blank
    cyc(1'b1, 9'd123);
    idle(40);

    // -256 -> 6,5,2,minus
    cyc(1'b1, 9'h100);
    idle(40);

    // -7
    cyc(1'b1, 9'h1F9);
    idle(40);

    // Load during conversion is ignored.
    cyc(1'b1, 9'd42);
    idle(3);
    cyc(1'b1, 9'd255);
    idle(40);

    // Reset mid-conversion after loading 200.
    cyc(1'b1, 9'd200);
    idle(4);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_anode_n", 32'(anode_n), 32'hF);
    chk("rst_seg_n", 32'(seg_n), 32'h7F);
    idle(2);
    rst_n = 1'b1;
    idle(30);

    // load held high with 5: reloads every 11 cycles, display stays stable.
    for (int i = 0; i < 60; i++) cyc(1'b1, 9'd5);
    idle(20);

    // Random traffic, including bursts of held load.
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 5) == 0), 9'($urandom));
    end
    for (int i = 0; i < 40; i++) cyc(1'b1, 9'($urandom));
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
